sigmoid_pipe: RTL and testbench



---
 rtl/sigmoid_pkg.sv | 29 ++
 rtl/sigmoid_plan_seg.sv | 35 +++
 rtl/sigmoid_pipe.sv | 102 ++++++++++
 tb/tb_sigmoid_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared constants for the PLAN sigmoid/tanh pipeline: breakpoints, offsets,
// slope shifts, mode encoding and the region type.
package sigmoid_pkg;

  // Breakpoints on |a| in 1/8 units: 1.0, 2.375, 5.0
  localparam int BP_R1_8 = 8;
  localparam int BP_R2_8 = 19;
  localparam int BP_R3_8 = 40;

  // Segment offsets in 1/32 units: 0.5, 0.625, 0.84375
  localparam int OFF_R0_32 = 16;
  localparam int OFF_R1_32 = 20;
  localparam int OFF_R2_32 = 27;

  localparam int SH_R0 = 2;
  localparam int SH_R1 = 3;
  localparam int SH_R2 = 5;

  localparam logic MODE_SIG  = 1'b0;
  localparam logic MODE_TANH = 1'b1;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } region_e;

endpackage

// File: rtl/sigmoid_plan_seg.sv
// Combinational PLAN segment evaluator: maps |a|, region and sign to s in
// [0, 1.0] with F = OW-1 fraction bits. Every shift is exact.
module sigmoid_plan_seg
  import sigmoid_pkg::*;
#(
  parameter int IW = 8,
  parameter int FI = 5,
  parameter int OW = 16
) (
  input  logic [IW:0]   abs_i,
  input  region_e       region_i,
  input  logic          neg_i,
  output logic [OW-1:0] s_o
);

  localparam int F  = OW - 1;
  localparam int PW = OW + IW + 2;
  localparam logic [PW-1:0] ONE = PW'(1) << F;

  logic [PW-1:0] al;
  logic [PW-1:0] p;

  always_comb begin
    al = PW'(abs_i) << (F - FI);
    case (region_i)
      R0:      p = (al >> SH_R0) + (PW'(OFF_R0_32) << (F - 5));
      R1:      p = (al >> SH_R1) + (PW'(OFF_R1_32) << (F - 5));
      R2:      p = (al >> SH_R2) + (PW'(OFF_R2_32) << (F - 5));
      default: p = ONE;
    endcase
    // Negative arguments use the odd symmetry sigma(-a) = 1 - sigma(a)
    s_o = neg_i ? OW'(ONE - p) : OW'(p);
  end

endmodule

// File: rtl/sigmoid_pipe.sv
// Two-stage streaming PLAN sigmoid/tanh unit with valid/ready backpressure.
// Stage 1 classifies the argument, stage 2 evaluates the segment and formats.
module sigmoid_pipe
  import sigmoid_pkg::*;
#(
  parameter int IW = 8,
  parameter int FI = 5,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic signed [IW-1:0] i_x,
  input  logic                 i_mode,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [OW-1:0]        o_y,
  output logic                 o_sat
);

  localparam int F     = OW - 1;
  localparam int TH_R1 = BP_R1_8 << (FI - 3);
  localparam int TH_R2 = BP_R2_8 << (FI - 3);
  localparam int TH_R3 = BP_R3_8 << (FI - 3);
  localparam logic signed [OW+1:0] ONE_T = (OW+2)'(1) << F;

  // t = 2s - 1; the single unrepresentable value +1.0 clips to 2^F-1
  function automatic logic [OW-1:0] tanh_sat(input logic [OW-1:0] s);
    logic signed [OW+1:0] t;
    t = $signed({1'b0, s, 1'b0}) - ONE_T;
    return (t == ONE_T) ? OW'(ONE_T - 1) : t[OW-1:0];
  endfunction

  logic                 vld_p1_q, vld_p2_q, rdy_p2;
  logic signed [IW:0]   a_d;
  logic [IW:0]          abs_d;
  region_e              region_d;
  logic                 neg_p1_q, mode_p1_q;
  logic [IW:0]          abs_p1_q;
  region_e              region_p1_q;
  logic [OW-1:0]        s_p2, y_d, y_p2_q;
  logic                 sat_d, sat_p2_q;

  assign rdy_p2      = !vld_p2_q || i_out_ready;
  assign o_in_ready  = !rst && (!vld_p1_q || rdy_p2);
  assign o_out_valid = vld_p2_q;
  assign o_y         = y_p2_q;
  assign o_sat       = sat_p2_q;

  // ---- stage 1: argument, magnitude, region ----
  always_comb begin
    a_d   = (i_mode == MODE_TANH) ? {i_x, 1'b0} : {i_x[IW-1], i_x};
    abs_d = a_d[IW] ? (~a_d + 1'b1) : a_d;
    if (int'(abs_d) >= TH_R3)      region_d = R3;
    else if (int'(abs_d) >= TH_R2) region_d = R2;
    else if (int'(abs_d) >= TH_R1) region_d = R1;
    else                           region_d = R0;
  end

  always_ff @(posedge clk) begin
    if (o_in_ready && i_in_valid) begin
      neg_p1_q    <= a_d[IW];
      abs_p1_q    <= abs_d;
      mode_p1_q   <= i_mode;
      region_p1_q <= region_d;
    end
  end

  // ---- stage 2: segment value and output format ----
  sigmoid_plan_seg #(.IW(IW), .FI(FI), .OW(OW)) u_seg (
    .abs_i    (abs_p1_q),
    .region_i (region_p1_q),
    .neg_i    (neg_p1_q),
    .s_o      (s_p2)
  );

  always_comb begin
    y_d   = (mode_p1_q == MODE_TANH) ? tanh_sat(s_p2) : s_p2;
    sat_d = (region_p1_q == R3);
  end

  // Outputs are cleared by reset so nothing stale is visible after abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      y_p2_q   <= '0;
      sat_p2_q <= 1'b0;
    end else begin
      if (o_in_ready) vld_p1_q <= i_in_valid;
      if (rdy_p2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          y_p2_q   <= y_d;
          sat_p2_q <= sat_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Self-checking bench for sigmoid_pipe: directed vector table, backpressure,
// async reset abort and randomized valid/ready against a real-valued model.
module tb_sigmoid_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_in_valid;
  logic              o_in_ready;
  logic signed [7:0] i_x;
  logic              i_mode;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [15:0]       o_y;
  logic              o_sat;

  sigmoid_pipe #(.IW(8), .FI(5), .OW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_x         (i_x),
    .i_mode      (i_mode),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_y         (o_y),
    .o_sat       (o_sat)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] y; logic sat; } exp_t;
  typedef struct { logic [7:0] x; logic m; logic [15:0] y; logic sat; } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          acc_count = 0;
  int          out_count = 0;
  exp_t        expq[$];
  exp_t        e;
  logic [15:0] exp_y;
  logic        exp_sat;
  logic        stall_prev = 1'b0;
  logic [15:0] held_y;
  logic        held_sat;
  logic        rand_run;
  vec_t        tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: the piecewise-linear rules evaluated in real arithmetic
  function automatic void model(input logic [7:0] x, input logic m,
                                output logic [15:0] y, output logic sat);
    real xr, a, aa, p, sv, t;
    xr  = $itor($signed(x)) / 32.0;
    a   = m ? 2.0 * xr : xr;
    aa  = (a < 0.0) ? -a : a;
    sat = 1'b0;
    if (aa >= 5.0) begin p = 1.0; sat = 1'b1; end
    else if (aa >= 2.375) p = aa / 32.0 + 0.84375;
    else if (aa >= 1.0)   p = aa / 8.0 + 0.625;
    else                  p = aa / 4.0 + 0.5;
    sv = (a >= 0.0) ? p : 1.0 - p;
    if (!m) y = 16'($rtoi(sv * 32768.0));
    else begin
      t = 2.0 * sv - 1.0;
      if (t >= 1.0) y = 16'h7FFF;
      else          y = 16'($rtoi(t * 32768.0));
    end
  endfunction

  // Monitor: pops/compares consumed outputs, queues accepted expectations,
  // and checks that a stalled output is held stable.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && o_out_valid) begin
        chk("stall_hold_y", 32'(o_y), 32'(held_y));
        chk("stall_hold_sat", 32'(o_sat), 32'(held_sat));
      end
      stall_prev = o_out_valid && !i_out_ready;
      held_y     = o_y;
      held_sat   = o_sat;
      if (o_out_valid && i_out_ready) begin
        out_count++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%0h required=none", o_y);
        end else begin
          e = expq.pop_front();
          chk("out_y", 32'(o_y), 32'(e.y));
          chk("out_sat", 32'(o_sat), 32'(e.sat));
        end
      end
      if (i_in_valid && o_in_ready) begin
        acc_count++;
        expq.push_back('{exp_y, exp_sat});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [7:0] x, input logic m, input logic [15:0] ey, input logic es);
    int n = 0;
    i_in_valid = 1'b1;
    i_x        = x;
    i_mode     = m;
    exp_y      = ey;
    exp_sat    = es;
    forever begin
      @(negedge clk);
      if (o_in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=blocked required=accepted");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    i_out_ready = 1'b1;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  rx;
    logic        rm;
    logic [15:0] ry;
    logic        rs;
    int          acc0;

    tbl[0]  = '{8'h00, 1'b0, 16'h4000, 1'b0};
    tbl[1]  = '{8'h20, 1'b0, 16'h6000, 1'b0};
    tbl[2]  = '{8'hE0, 1'b0, 16'h2000, 1'b0};
    tbl[3]  = '{8'h60, 1'b0, 16'h7800, 1'b0};
    tbl[4]  = '{8'h80, 1'b0, 16'h0400, 1'b0};
    tbl[5]  = '{8'h20, 1'b1, 16'h6000, 1'b0};
    tbl[6]  = '{8'hE0, 1'b1, 16'hA000, 1'b0};
    tbl[7]  = '{8'h60, 1'b1, 16'h7FFF, 1'b1};
    tbl[8]  = '{8'h80, 1'b1, 16'h8000, 1'b1};
    tbl[9]  = '{8'h4C, 1'b0, 16'h7580, 1'b0};
    tbl[10] = '{8'h4B, 1'b0, 16'h7580, 1'b0};
    tbl[11] = '{8'hA0, 1'b0, 16'h0800, 1'b0};
    tbl[12] = '{8'h7F, 1'b0, 16'h7BE0, 1'b0};
    tbl[13] = '{8'h10, 1'b1, 16'h4000, 1'b0};
    tbl[14] = '{8'h50, 1'b1, 16'h7FFF, 1'b1};
    tbl[15] = '{8'hB0, 1'b1, 16'h8000, 1'b1};
    tbl[16] = '{8'h1F, 1'b0, 16'h5F00, 1'b0};

    rst = 1'b1; i_in_valid = 1'b0; i_x = '0; i_mode = 1'b0;
    i_out_ready = 1'b1; exp_y = '0; exp_sat = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_sat", 32'(o_sat), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: result visible two edges after acceptance
    send(8'h00, 1'b0, 16'h4000, 1'b0);
    @(negedge clk);
    chk("lat_valid_1", 32'(o_out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_2", 32'(o_out_valid), 32'd1);
    chk("lat_y", 32'(o_y), 32'h4000);
    @(posedge clk);
    #1;

    // Directed vectors streamed back-to-back
    for (int i = 0; i < 17; i++) send(tbl[i].x, tbl[i].m, tbl[i].y, tbl[i].sat);
    drain();

    // Backpressure: output blocked for 5 cycles while 4 samples are offered
    i_out_ready = 1'b0;
    acc0 = acc_count;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          rx = 8'(8'h10 + 8'(i * 8'h50));
          rm = i[0];
          model(rx, rm, ry, rs);
          send(rx, rm, ry, rs);
        end
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 32'(o_in_ready), 32'd0);
        chk("bp_accepts", 32'(acc_count - acc0), 32'd2);
        chk("bp_out_valid", 32'(o_out_valid), 32'd1);
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 32'(acc_count - acc0), 32'd4);

    // Randomized valid/ready with mixed modes
    rand_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          rx = 8'($urandom_range(0, 255));
          rm = 1'($urandom_range(0, 1));
          model(rx, rm, ry, rs);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rx, rm, ry, rs);
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("in_out_count", 32'(out_count), 32'(acc_count));

    // Async reset with two samples in flight
    i_out_ready = 1'b0;
    send(8'h20, 1'b0, 16'h6000, 1'b0);
    send(8'hE0, 1'b0, 16'h2000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expq.delete();
    chk("abort_out_valid", 32'(o_out_valid), 32'd0);
    chk("abort_y", 32'(o_y), 32'd0);
    chk("abort_sat", 32'(o_sat), 32'd0);
    chk("abort_in_ready", 32'(o_in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("abort_ready_release", 32'(o_in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_stale", 32'(o_out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(8'h60, 1'b1, 16'h7FFF, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
